// File: rtl/jtpopeye_dwnld_router.sv
// jtpopeye_dwnld_router
//   Routes the ioctl download byte stream to the game's ROM stores. Bytes below PROM_START
//   become SDRAM programming requests (word address plus active-low byte-lane mask) held
//   until the SDRAM acknowledges them, with one extra byte of buffering behind the live
//   request. Bytes from PROM_START upwards are decoded into one-hot PROM write pulses.
//   Also produces a download-done pulse and sticky range/overflow error flags.
//
// Optional feature macro: JTPOPEYE_DWNLD_CHKSUM_EN
//   Defined   : o_chksum is a running 16-bit sum of every accepted byte.
//   Undefined : o_chksum is tied to zero.
//
// Ports
//   i_clk, i_rst_n            download clock, asynchronous active-low reset
//   i_downloading             download window
//   i_ioctl_addr/data/wr      byte address, byte data, one-cycle byte strobe
//   o_prog_addr/data/mask/we  SDRAM request (or PROM offset/data during a PROM pulse)
//   i_prog_ack                SDRAM accepted the current request
//   o_prom_we                 one-hot PROM write pulse
//   o_dwnld_done              one-cycle pulse after the download window closes
//   o_err_range, o_err_ovf    sticky error flags, cleared when a new download opens
//   o_chksum                  running byte sum
module jtpopeye_dwnld_router #(
  parameter int unsigned   AW         = 22,
  parameter logic [AW-1:0] PROM_START = AW'(32'h10000),
  parameter int unsigned   PROM_CNT   = 6,
  parameter int unsigned   PROM_AW    = 11
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_downloading,
  input  logic [AW-1:0]       i_ioctl_addr,
  input  logic [7:0]          i_ioctl_data,
  input  logic                i_ioctl_wr,
  output logic [AW-1:0]       o_prog_addr,
  output logic [7:0]          o_prog_data,
  output logic [1:0]          o_prog_mask,
  output logic                o_prog_we,
  input  logic                i_prog_ack,
  output logic [PROM_CNT-1:0] o_prom_we,
  output logic                o_dwnld_done,
  output logic                o_err_range,
  output logic                o_err_ovf,
  output logic [15:0]         o_chksum
);

  localparam int unsigned   IdxW     = AW - PROM_AW;
  localparam logic [AW-1:0] PromSpan = AW'(PROM_CNT) << PROM_AW;

  typedef enum logic [0:0] {StIdle, StReq} state_t;

  // Input decode
  logic                w_acc;
  logic [AW-1:0]       w_rel;
  logic                w_is_prom;
  logic                w_prom_ok;
  logic                w_sd_byte;
  logic                w_range;
  logic [PROM_CNT-1:0] w_prom_hit;
  logic [AW-1:0]       w_new_addr;
  logic [1:0]          w_new_mask;

  assign w_acc      = i_ioctl_wr && i_downloading;
  assign w_rel      = i_ioctl_addr - PROM_START;
  assign w_is_prom  = i_ioctl_addr >= PROM_START;
  assign w_prom_ok  = w_acc && w_is_prom && (w_rel < PromSpan);
  assign w_sd_byte  = w_acc && !w_is_prom;
  assign w_range    = w_acc && w_is_prom && !(w_rel < PromSpan);
  assign w_new_addr = {1'b0, i_ioctl_addr[AW-1:1]};
  assign w_new_mask = i_ioctl_addr[0] ? 2'b01 : 2'b10;

  always_comb begin
    w_prom_hit = '0;
    for (int i = 0; i < PROM_CNT; i++) begin
      w_prom_hit[i] = w_prom_ok && (w_rel[AW-1:PROM_AW] == IdxW'(i));
    end
  end

  // PROM pulse registers
  logic [PROM_CNT-1:0] r_prom_we;
  logic [PROM_AW-1:0]  r_prom_off;
  logic [7:0]          r_prom_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prom_we   <= '0;
      r_prom_off  <= '0;
      r_prom_data <= '0;
    end else begin
      r_prom_we <= w_prom_hit;
      if (w_prom_ok) begin
        r_prom_off  <= w_rel[PROM_AW-1:0];
        r_prom_data <= i_ioctl_data;
      end
    end
  end

  // SDRAM request FSM with a one-entry holding buffer
  state_t        r_state;
  logic [AW-1:0] r_req_addr;
  logic [7:0]    r_req_data;
  logic [1:0]    r_req_mask;
  logic          r_buf_vld;
  logic [AW-1:0] r_buf_addr;
  logic [7:0]    r_buf_data;
  logic [1:0]    r_buf_mask;
  logic          w_ack;
  logic          w_ovf;

  // The PROM pulse borrows the shared address/data bus, so an ack seen then is not ours.
  assign w_ack = i_prog_ack && (r_state == StReq) && (r_prom_we == '0);
  assign w_ovf = w_sd_byte && (r_state == StReq) && !w_ack && r_buf_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_req_addr <= '0;
      r_req_data <= '0;
      r_req_mask <= 2'b11;
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_buf_mask <= 2'b11;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_sd_byte) begin
            r_req_addr <= w_new_addr;
            r_req_data <= i_ioctl_data;
            r_req_mask <= w_new_mask;
            r_state    <= StReq;
          end
        end
        StReq: begin
          if (w_ack) begin
            if (r_buf_vld) begin
              // Buffered byte issues; a simultaneous new byte takes its place.
              r_req_addr <= r_buf_addr;
              r_req_data <= r_buf_data;
              r_req_mask <= r_buf_mask;
              if (w_sd_byte) begin
                r_buf_addr <= w_new_addr;
                r_buf_data <= i_ioctl_data;
                r_buf_mask <= w_new_mask;
              end else begin
                r_buf_vld <= 1'b0;
              end
            end else if (w_sd_byte) begin
              // New byte passes straight through the (empty) buffer.
              r_req_addr <= w_new_addr;
              r_req_data <= i_ioctl_data;
              r_req_mask <= w_new_mask;
            end else begin
              r_req_mask <= 2'b11;
              r_state    <= StIdle;
            end
          end else if (w_sd_byte && !r_buf_vld) begin
            r_buf_vld  <= 1'b1;
            r_buf_addr <= w_new_addr;
            r_buf_data <= i_ioctl_data;
            r_buf_mask <= w_new_mask;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Download window edges and sticky flags
  logic r_dl;
  logic r_done;
  logic r_err_range;
  logic r_err_ovf;
  logic w_rise;

  assign w_rise = i_downloading && !r_dl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dl        <= 1'b0;
      r_done      <= 1'b0;
      r_err_range <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_dl        <= i_downloading;
      r_done      <= r_dl && !i_downloading;
      r_err_range <= (r_err_range && !w_rise) || w_range;
      r_err_ovf   <= (r_err_ovf && !w_rise) || w_ovf;
    end
  end

`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  logic [15:0] r_chksum;

  // Every accepted byte counts, including ones later dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chksum <= '0;
    end else begin
      r_chksum <= (w_rise ? 16'h0 : r_chksum) + (w_acc ? {8'h0, i_ioctl_data} : 16'h0);
    end
  end

  assign o_chksum = r_chksum;
`else
  assign o_chksum = 16'h0;
`endif

  // Outputs
  assign o_prog_addr  = (r_prom_we != '0) ? {{IdxW{1'b0}}, r_prom_off} : r_req_addr;
  assign o_prog_data  = (r_prom_we != '0) ? r_prom_data : r_req_data;
  assign o_prog_mask  = r_req_mask;
  assign o_prog_we    = (r_state == StReq);
  assign o_prom_we    = r_prom_we;
  assign o_dwnld_done = r_done;
  assign o_err_range  = r_err_range;
  assign o_err_ovf    = r_err_ovf;

endmodule
